// File: rtl/spi_frame_tx_pkg.sv
// Frame layout and FSM encoding for the router's serial link.
// The receive path of the router uses the same constants.
package spi_frame_tx_pkg;

  localparam int unsigned FRAME_BITS = 25;
  localparam int unsigned DEST_MSB   = 24;
  localparam int unsigned DATA_MSB   = 16;
  localparam int unsigned CHK_MSB    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } txState_t;

endpackage

// File: rtl/adder.sv
// Unsigned adder with the carry kept as the result MSB.
module adder #(
  parameter int unsigned size = 8
) (
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  output logic [size:0]   sum
);

  assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/spi_frame_tx.sv
// Serial frame transmitter: shifts {dest, data, checksum} out MSB-first on a
// divided serial clock, with a select covering the whole frame.
module spi_frame_tx
  import spi_frame_tx_pkg::*;
#(
  parameter int unsigned size   = 8,
  parameter int unsigned clkDiv = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [size-1:0] destIn,
  input  logic [size-1:0] dataIn,
  output logic            ready,
  output logic            enableSpi,
  output logic            masterClock,
  output logic            bitOut,
  output logic            done
);

  localparam int unsigned DIV_W = (clkDiv > 1) ? $clog2(clkDiv) : 1;
  localparam int unsigned BIT_W = 5;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(clkDiv - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  txState_t              state;
  txState_t              stateNext;
  logic [FRAME_BITS-1:0] shiftReg;
  logic [FRAME_BITS-1:0] shiftNext;
  logic [DIV_W-1:0]      divCnt;
  logic [DIV_W-1:0]      divNext;
  logic [BIT_W-1:0]      bitCnt;
  logic [BIT_W-1:0]      bitNext;
  logic                  sclk;
  logic                  sclkNext;
  logic [size:0]         checksum;

  adder #(.size(size)) uChecksum (
    .a   (destIn),
    .b   (dataIn),
    .sum (checksum)
  );

  // State, shift register, counters and serial clock phase.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shiftReg <= '0;
      divCnt   <= '0;
      bitCnt   <= '0;
      sclk     <= 1'b0;
    end else begin
      state    <= stateNext;
      shiftReg <= shiftNext;
      divCnt   <= divNext;
      bitCnt   <= bitNext;
      sclk     <= sclkNext;
    end
  end

  // Next-state: each bit is a low phase then a high phase of clkDiv cycles;
  // data advances only when a high phase ends, i.e. on the falling edge.
  always_comb begin
    stateNext = state;
    shiftNext = shiftReg;
    divNext   = divCnt;
    bitNext   = bitCnt;
    sclkNext  = sclk;
    unique case (state)
      IDLE: begin
        sclkNext = 1'b0;
        if (start) begin
          stateNext                      = SHIFT;
          shiftNext[DEST_MSB -: size]    = destIn;
          shiftNext[DATA_MSB -: size]    = dataIn;
          shiftNext[CHK_MSB:0]           = checksum;
          divNext                        = '0;
          bitNext                        = '0;
        end
      end
      SHIFT: begin
        if (divCnt == DIV_LAST) begin
          divNext = '0;
          if (!sclk) begin
            sclkNext = 1'b1;
          end else begin
            sclkNext = 1'b0;
            if (bitCnt < BIT_LAST) begin
              shiftNext = {shiftReg[FRAME_BITS-2:0], 1'b0};
              bitNext   = bitCnt + BIT_W'(1);
            end else begin
              stateNext = DONE;
            end
          end
        end else begin
          divNext = divCnt + DIV_W'(1);
        end
      end
      DONE: begin
        stateNext = IDLE;
        sclkNext  = 1'b0;
      end
      default: begin
        stateNext = IDLE;
        sclkNext  = 1'b0;
      end
    endcase
  end

  assign ready       = (state == IDLE);
  assign enableSpi   = (state == SHIFT);
  assign done        = (state == DONE);
  assign masterClock = sclk;
  assign bitOut      = (state == SHIFT) & shiftReg[DEST_MSB];

endmodule

// File: tb/tb_spi_frame_tx.sv
// Scoreboard bench: two transmitters (clkDiv 4 and 1) feed a receiver model
// that samples on rising masterClock; frames and timing are checked at done.
module tb_spi_frame_tx;

  localparam int unsigned NDUT = 2;
  localparam int unsigned CD [NDUT] = '{4, 1};

  typedef struct {
    int unsigned inst;
    logic [24:0] frame;
    int          e0;
  } exp_t;

  logic            clock = 1'b0;
  logic            rst_n = 1'b0;
  logic [NDUT-1:0] start;
  logic [7:0]      destIn [NDUT];
  logic [7:0]      dataIn [NDUT];
  logic [NDUT-1:0] ready, enableSpi, masterClock, bitOut, done;

  exp_t expQ[$];
  int   cyc = 0;
  int   nCompared = 0;
  int   nMismatched = 0;

  logic [24:0] cap   [NDUT];
  int          nRise [NDUT];
  int          enCnt [NDUT];
  int          hiCnt [NDUT];
  logic        prevM [NDUT];
  bit          seenEn[NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    spi_frame_tx #(.size(8), .clkDiv(CD[g])) dut (
      .clock       (clock),
      .reset       (rst_n),
      .start       (start[g]),
      .destIn      (destIn[g]),
      .dataIn      (dataIn[g]),
      .ready       (ready[g]),
      .enableSpi   (enableSpi[g]),
      .masterClock (masterClock[g]),
      .bitOut      (bitOut[g]),
      .done        (done[g])
    );
  end

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [24:0] mkFrame(input logic [7:0] d, input logic [7:0] v);
    logic [8:0] s;
    s = {1'b0, d} + {1'b0, v};
    return {d, v, s};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearMon(input int k);
    cap[k]    = '0;
    nRise[k]  = 0;
    enCnt[k]  = 0;
    hiCnt[k]  = 0;
    prevM[k]  = 1'b0;
    seenEn[k] = 1'b0;
  endtask

  task automatic sendFrame(input int k, input logic [7:0] d, input logic [7:0] v, output int e0);
    exp_t e;
    destIn[k] = d;
    dataIn[k] = v;
    start[k]  = 1'b1;
    e0        = cyc + 1;
    e.inst    = k;
    e.frame   = mkFrame(d, v);
    e.e0      = e0;
    expQ.push_back(e);
    tick();
    start[k]  = 1'b0;
    destIn[k] = ~d;
    dataIn[k] = ~v;
  endtask

  task automatic waitDrain(input int limit);
    int n = 0;
    while (expQ.size() > 0 && n < limit) begin
      tick();
      n++;
    end
    if (expQ.size() > 0) begin
      checkEq("timeout", 32'(expQ.size()), 32'd0);
      expQ.delete();
    end
    tick();
  endtask

  task automatic checkIdleOuts(input string tag);
    for (int k = 0; k < NDUT; k++)
      checkEq($sformatf("%s[%0d]", tag, k),
              32'({ready[k], enableSpi[k], masterClock[k], bitOut[k], done[k]}), 32'h10);
  endtask

  // Receiver model and per-frame timing checks.
  initial begin
    exp_t e;
    for (int k = 0; k < NDUT; k++) clearMon(k);
    forever begin
      @(negedge clock);
      for (int k = 0; k < NDUT; k++) begin
        if (!rst_n) begin
          clearMon(k);
          continue;
        end
        if (enableSpi[k]) begin
          enCnt[k]++;
          if (!seenEn[k]) begin
            seenEn[k] = 1'b1;
            if (expQ.size() > 0 && expQ[0].inst == k) begin
              checkEq($sformatf("enLatency[%0d]", k), 32'(cyc - expQ[0].e0), 32'd0);
              checkEq($sformatf("firstBit[%0d]", k), 32'(bitOut[k]), 32'(expQ[0].frame[24]));
            end else begin
              checkEq($sformatf("spuriousEnable[%0d]", k), 32'd1, 32'd0);
            end
          end
          if (masterClock[k] && !prevM[k]) begin
            cap[k] = {cap[k][23:0], bitOut[k]};
            nRise[k]++;
            if (nRise[k] == 1 && expQ.size() > 0 && expQ[0].inst == k)
              checkEq($sformatf("riseLatency[%0d]", k), 32'(cyc - expQ[0].e0), 32'(CD[k]));
          end
          if (masterClock[k]) hiCnt[k]++;
        end
        prevM[k] = masterClock[k];
        if (done[k]) begin
          if (expQ.size() == 0 || expQ[0].inst != k) begin
            checkEq($sformatf("unexpectedFrame[%0d]", k), 32'd1, 32'd0);
          end else begin
            e = expQ.pop_front();
            checkEq($sformatf("frame[%0d]", k), 32'(cap[k]), 32'(e.frame));
            checkEq($sformatf("bitCount[%0d]", k), 32'(nRise[k]), 32'd25);
            checkEq($sformatf("shiftCycles[%0d]", k), 32'(enCnt[k]), 32'(50 * CD[k]));
            checkEq($sformatf("highCycles[%0d]", k), 32'(hiCnt[k]), 32'(25 * CD[k]));
            checkEq($sformatf("doneLatency[%0d]", k), 32'(cyc - e.e0), 32'(50 * CD[k]));
            checkEq($sformatf("doneOuts[%0d]", k),
                    32'({ready[k], enableSpi[k], masterClock[k], bitOut[k]}), 32'd0);
          end
          clearMon(k);
        end
      end
    end
  end

  initial begin
    int e0;
    int eDummy;
    start = '0;
    for (int k = 0; k < NDUT; k++) begin
      destIn[k] = '0;
      dataIn[k] = '0;
    end
    rst_n = 1'b0;
    repeat (3) tick();
    checkIdleOuts("resetOuts");
    rst_n = 1'b1;
    tick();
    checkIdleOuts("idleOuts");

    // Nominal frame and carry case.
    sendFrame(0, 8'h80, 8'h01, eDummy);
    waitDrain(400);
    sendFrame(0, 8'hFF, 8'hFF, eDummy);
    waitDrain(400);

    // Starts mid-frame and in the done cycle are ignored; ready-cycle start is taken.
    sendFrame(0, 8'h3C, 8'hA5, e0);
    repeat (49) tick();
    destIn[0] = 8'h11;
    dataIn[0] = 8'h22;
    start[0]  = 1'b1;
    tick();
    start[0]  = 1'b0;
    while (cyc < e0 + 200) tick();
    destIn[0] = 8'h55;
    dataIn[0] = 8'h66;
    start[0]  = 1'b1;
    tick();
    start[0]  = 1'b0;
    sendFrame(0, 8'h5A, 8'hC3, eDummy);
    waitDrain(900);

    // Minimum divider.
    sendFrame(1, 8'h7F, 8'h00, eDummy);
    waitDrain(200);

    // Reset mid-frame abandons the frame.
    sendFrame(0, 8'h9A, 8'h3B, eDummy);
    repeat (59) tick();
    #2 rst_n = 1'b0;
    #1 checkIdleOuts("midFrameReset");
    void'(expQ.pop_back());
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (250) tick();
    sendFrame(0, 8'h80, 8'h01, eDummy);
    waitDrain(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
